// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one uart_tx serializer between N_REQ byte streams.
// Optional watchdog on the done handshake is enabled by defining TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned NB_GRANT       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_done,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy,
    output logic                     o_timeout
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    localparam bit ParamsOk = (N_REQ >= 2) && (N_REQ <= 8) && ((2 ** NB_GRANT) >= N_REQ)
                              && (TIMEOUT_CYCLES > 0);

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [NB_GRANT-1:0]  gidx_q, gidx_d;
    logic [NB_GRANT-1:0]  ptr_q, ptr_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 last_q, last_d;
    logic                 start_q, start_d;

    logic [NB_GRANT-1:0]  cand;
    logic [NB_GRANT-1:0]  pick;
    logic                 pick_vld;
    logic                 valid_g;
    logic                 last_g;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int unsigned NbWdog = $clog2(TIMEOUT_CYCLES + 1);

    logic [NbWdog-1:0]    wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;
`endif

    // First valid requester after the pointer, wrapping modulo N_REQ.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = NB_GRANT'((int'(ptr_q) + i) % int'(N_REQ));
            if (!pick_vld && ((i_req_valid & (N_REQ'(1) << cand)) != '0)) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign valid_g = |(i_req_valid & grant_q);
    assign last_g  = |(i_req_last & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        start_d   = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d = N_REQ'(1) << pick;
                    gidx_d  = pick;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (valid_g) begin
                    tx_data_d = NB_DATA'(i_req_data >> (int'(gidx_q) * int'(NB_DATA)));
                    last_d    = last_g;
                    start_d   = 1'b1;
                    state_d   = StWait;
`ifdef TX_ARB_WATCHDOG_EN
                    wdog_d    = '0;
`endif
                end
            end
            StWait: begin
`ifdef TX_ARB_WATCHDOG_EN
                wdog_d = wdog_q + NbWdog'(1);
`endif
                // A done tick coincident with the start pulse belongs to no byte of ours.
                if (i_tx_done && !start_q) begin
                    if (last_q) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
`ifdef TX_ARB_WATCHDOG_EN
                else if (wdog_q == NbWdog'(TIMEOUT_CYCLES - 1)) begin
                    ptr_d     = gidx_q;
                    grant_d   = '0;
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= NB_GRANT'(N_REQ - 1);
            tx_data_q <= '0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            start_q   <= start_d;
        end
    end

`ifdef TX_ARB_WATCHDOG_EN
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_req_ready = (state_q == StSend) ? (grant_q & i_req_valid) : '0;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = start_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q != StIdle);

    a_params_ok: assert property (@(posedge clk) ParamsOk);
    a_ready_onehot: assert property (@(posedge clk) disable iff (i_rst) $onehot0(o_req_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases and a randomized
// run scored against a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NB = 8;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [NR-1:0]   i_req_valid;
    logic [NR*NB-1:0] i_req_data;
    logic [NR-1:0]   i_req_last;
    logic [NR-1:0]   o_req_ready;
    logic [NB-1:0]   o_tx_data;
    logic            o_tx_start;
    logic            i_tx_done;
    logic [NR-1:0]   o_grant;
    logic            o_busy;
    logic            o_timeout;

    uart_tx_arbiter #(
        .NB_DATA        (NB),
        .N_REQ          (NR),
        .NB_GRANT       (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .i_tx_done   (i_tx_done),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_log[$];
    logic [NR-1:0] en;
    int ready_cnt0, ready_cnt1, bad_ready, timeout_cnt;
    bit uart_auto;
    int uart_lat, uart_cnt, mptr;

    typedef struct {
        logic [1:0] vmask;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nexp;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        i_req_valid[0] = en[0] && (q0.size() > 0);
        i_req_valid[1] = en[1] && (q1.size() > 0);
        if (q0.size() > 0) begin
            i_req_data[7:0] = q0[0][7:0];
            i_req_last[0]   = q0[0][8];
        end else begin
            i_req_data[7:0] = 8'($urandom);
            i_req_last[0]   = 1'($urandom);
        end
        if (q1.size() > 0) begin
            i_req_data[15:8] = q1[0][7:0];
            i_req_last[1]    = q1[0][8];
        end else begin
            i_req_data[15:8] = 8'($urandom);
            i_req_last[1]    = 1'($urandom);
        end
    endtask

    // One clock: handshake sampled mid-cycle, then queues, uart model and log updated after the edge.
    task automatic tick();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = i_req_valid & o_req_ready;
        if (!$onehot0(o_req_ready) || ((o_req_ready & ~o_grant) != '0)) bad_ready++;
        if (o_req_ready[0]) ready_cnt0++;
        if (o_req_ready[1]) ready_cnt1++;
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        if (o_timeout) timeout_cnt++;
        i_tx_done = 1'b0;
        if (o_tx_start) begin
            tx_log.push_back(o_tx_data);
            if (uart_auto) uart_cnt = uart_lat;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) i_tx_done = 1'b1;
        end
        drive();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        q0.delete();
        q1.delete();
        tx_log.delete();
        en = '1;
        uart_auto = 1'b1;
        uart_lat = 3;
        uart_cnt = 0;
        i_tx_done = 1'b0;
        ready_cnt0 = 0;
        ready_cnt1 = 0;
        bad_ready = 0;
        mptr = 1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !o_busy && uart_cnt == 0) && n < bound) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 32'(n < bound), 1);
    endtask

    // Expected TX order: whole messages, round-robin over requesters with pending bytes.
    task automatic model_order();
        logic [8:0] e;
        bit found;
        int k;
        exp_log.delete();
        while (m0.size() > 0 || m1.size() > 0) begin
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                k = (mptr + i) % NR;
                if (!found && k == 0 && m0.size() > 0) begin
                    do begin e = m0.pop_front(); exp_log.push_back(e[7:0]); end
                    while (!e[8] && m0.size() > 0);
                    mptr = 0;
                    found = 1'b1;
                end else if (!found && k == 1 && m1.size() > 0) begin
                    do begin e = m1.pop_front(); exp_log.push_back(e[7:0]); end
                    while (!e[8] && m1.size() > 0);
                    mptr = 1;
                    found = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, mism, len;
        timeout_cnt = 0;
        tbl[0] = '{2'b11, 8'hA1, 8'hB2, 2, 8'hA1, 8'hB2};
        tbl[1] = '{2'b11, 8'hA1, 8'hB2, 2, 8'hA1, 8'hB2};
        tbl[2] = '{2'b10, 8'h00, 8'h5A, 1, 8'h5A, 8'h00};
        tbl[3] = '{2'b11, 8'hC3, 8'hD4, 2, 8'hC3, 8'hD4};
        tbl[4] = '{2'b01, 8'h77, 8'h00, 1, 8'h77, 8'h00};
        tbl[5] = '{2'b11, 8'hE5, 8'hF6, 2, 8'hF6, 8'hE5};
        tbl[6] = '{2'b11, 8'h12, 8'h34, 2, 8'h34, 8'h12};

        // Reset values, checked while reset is held.
        i_rst = 1'b1;
        en = '1;
        i_tx_done = 1'b0;
        drive();
        #1;
        check("rst_ready", o_req_ready, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_start", o_tx_start, 0);
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_timeout", o_timeout, 0);
        do_reset();

        // Single-byte message, done 20 cycles after start.
        uart_lat = 20;
        q0.push_back(9'h13C);
        drive();
        tick();
        check("t1_grant", o_grant, 2'b01);
        drain("t1", 100);
        check("t1_ntx", tx_log.size(), 1);
        check("t1_byte", tx_log[0], 8'h3C);
        check("t1_ready0", ready_cnt0, 1);
        check("t1_busy", o_busy, 0);
        check("t1_grant_idle", o_grant, 0);

        // Vector table of single-byte arbitrations; pointer carries across entries.
        do_reset();
        for (int v = 0; v < 7; v++) begin
            tx_log.delete();
            if (tbl[v].vmask[0]) q0.push_back({1'b1, tbl[v].d0});
            if (tbl[v].vmask[1]) q1.push_back({1'b1, tbl[v].d1});
            drive();
            drain($sformatf("vec%0d", v), 100);
            check($sformatf("vec%0d_ntx", v), tx_log.size(), tbl[v].nexp);
            check($sformatf("vec%0d_b0", v), tx_log[0], tbl[v].e0);
            if (tbl[v].nexp > 1) check($sformatf("vec%0d_b1", v), tx_log[1], tbl[v].e1);
        end

        // Multi-byte lock: req1 message while req0 waits.
        do_reset();
        uart_lat = 4;
        q1.push_back(9'h011);
        q1.push_back(9'h022);
        q1.push_back(9'h133);
        drive();
        tick();
        tick();
        q0.push_back(9'h199);
        drive();
        drain("lock", 200);
        check("lock_ntx", tx_log.size(), 4);
        check("lock_order", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h11223399);
        check("lock_ready0", ready_cnt0, 1);
        check("lock_bad_ready", bad_ready, 0);

        // Owner stalls mid-message; lock must hold.
        do_reset();
        q0.push_back(9'h001);
        q0.push_back(9'h102);
        q1.push_back(9'h155);
        drive();
        n = 0;
        while (q0.size() != 1 && n < 50) begin tick(); n++; end
        check("stall_reach", 32'(n < 50), 1);
        en[0] = 1'b0;
        drive();
        mism = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_grant != 2'b01) mism++;
        end
        check("stall_grant", mism, 0);
        check("stall_ntx", tx_log.size(), 1);
        check("stall_ready1", ready_cnt1, 0);
        en[0] = 1'b1;
        drive();
        drain("stall", 100);
        check("stall_order", {8'h00, tx_log[0], tx_log[1], tx_log[2]}, 32'h00010255);

        // Stray done in idle, done coincident with start, then async reset in WAIT.
        do_reset();
        i_tx_done = 1'b1;
        tick();
        tick();
        tick();
        check("idle_done_busy", o_busy, 0);
        check("idle_done_ntx", tx_log.size(), 0);
        check("idle_done_ready", ready_cnt0 + ready_cnt1, 0);
        uart_auto = 1'b0;
        q1.push_back(9'h1AB);
        drive();
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin tick(); n++; end
        check("early_reach", 32'(n < 50), 1);
        i_tx_done = 1'b1;
        tick();
        tick();
        check("early_done_busy", o_busy, 1);
        check("early_done_grant", o_grant, 2'b10);
        check("early_done_ntx", tx_log.size(), 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_outs", {o_req_ready, o_tx_data, o_tx_start, o_grant, o_busy}, 0);
        do_reset();
        q0.push_back(9'h1C0);
        q1.push_back(9'h1C1);
        drive();
        tick();
        check("arst_next_grant", o_grant, 2'b01);
        drain("arst", 100);
        check("arst_order", {tx_log[0], tx_log[1]}, 16'hC0C1);

        // Randomized rounds against the message-level model; owner's valid drops at random.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            tx_log.delete();
            for (int k = 0; k < NR; k++) begin
                for (int m = 0; m < int'($urandom_range(1, 3)); m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        if (k == 0) q0.push_back({1'(b == len - 1), 8'($urandom)});
                        else q1.push_back({1'(b == len - 1), 8'($urandom)});
                    end
                end
            end
            m0 = q0;
            m1 = q1;
            model_order();
            drive();
            n = 0;
            while (!(q0.size() == 0 && q1.size() == 0 && !o_busy && uart_cnt == 0) && n < 3000) begin
                uart_lat = $urandom_range(1, 6);
                tick();
                en = '1;
                if (o_grant[0]) en[0] = ($urandom_range(0, 3) != 0);
                if (o_grant[1]) en[1] = ($urandom_range(0, 3) != 0);
                drive();
                n++;
            end
            check($sformatf("rnd%0d_drain", r), 32'(n < 3000), 1);
            check($sformatf("rnd%0d_ntx", r), tx_log.size(), exp_log.size());
            mism = 0;
            for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
                if (tx_log[i] != exp_log[i]) mism++;
            check($sformatf("rnd%0d_bytes", r), mism, 0);
        end
        check("rnd_bad_ready", bad_ready, 0);

`ifdef TX_ARB_WATCHDOG_EN
        // Withheld done: timeout after 50 WAIT cycles, other requester granted next.
        do_reset();
        uart_auto = 1'b0;
        q0.push_back(9'h100);
        q1.push_back(9'h1AA);
        drive();
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin tick(); n++; end
        check("wd_reach", 32'(n < 50), 1);
        n = 0;
        while (!o_timeout && n < 100) begin tick(); n++; end
        check("wd_cycles", n, 50);
        check("wd_grant", o_grant, 0);
        tick();
        check("wd_timeout_pulse", o_timeout, 0);
        check("wd_next_grant", o_grant, 2'b10);
        uart_auto = 1'b1;
        drain("wd", 100);
        check("wd_second", tx_log[1], 8'hAA);
`else
        check("no_timeout_pulses", timeout_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
